// File: rtl/chargen_pkg.sv
// chargen_pkg: shared constants and FSM state type for the chargen source.
package chargen_pkg;
   localparam logic [7:0] CHAR_FIRST = 8'h20;
   localparam logic [7:0] CHAR_LAST  = 8'h7E;
   localparam int         CHAR_COUNT = 95;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;

   typedef enum logic [1:0] {IDLE, CHAR, CR, LF} state_t;
endpackage

// File: rtl/chargen_wrap_ctr.sv
// chargen_wrap_ctr: modulo counter 0..MAX with load priority over increment.
module chargen_wrap_ctr #(
   parameter int W   = 7,
   parameter int MAX = 94
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] init,
   input  logic         inc,
   output logic [W-1:0] q,
   output logic [W-1:0] succ
);
   assign succ = (q == W'(MAX)) ? '0 : q + W'(1);

   always_ff @(posedge clk)
      if (rst) q <= '0;
      else if (load) q <= init;
      else if (inc) q <= succ;
endmodule

// File: rtl/chargen.sv
// chargen: RFC 864 character-generator byte source on a valid/ready interface.
// Define CHARGEN_LED_EN to add the active-low line-activity led port.
module chargen
   import chargen_pkg::*;
#(
   parameter int LINE_LEN = 72
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       ready,
   output logic [7:0] data,
   output logic       valid
`ifdef CHARGEN_LED_EN
   ,
   output logic [2:0] led
`endif
);
   localparam logic [7:0] LAST_COL = 8'(LINE_LEN - 1);

   state_t     state, state_nx;
   logic [7:0] data_nx, col, col_nx;
   logic       valid_nx, chr_inc, chr_load, base_inc;
   logic [6:0] chr, chr_succ, base, base_succ;
   logic       xfer;

   assign xfer = valid && ready;

   // chr is reloaded from the successor of base when a line ends, so both move together
   chargen_wrap_ctr #(.W(7), .MAX(CHAR_COUNT - 1)) u_chr (
      .clk(clk), .rst(rst), .load(chr_load), .init(base_succ), .inc(chr_inc),
      .q(chr), .succ(chr_succ)
   );

   chargen_wrap_ctr #(.W(7), .MAX(CHAR_COUNT - 1)) u_base (
      .clk(clk), .rst(rst), .load(1'b0), .init(7'd0), .inc(base_inc),
      .q(base), .succ(base_succ)
   );

   always_comb begin
      state_nx = state;
      data_nx  = data;
      valid_nx = valid;
      col_nx   = col;
      chr_inc  = 1'b0;
      chr_load = 1'b0;
      base_inc = 1'b0;
      case (state)
         IDLE: if (en) begin
            state_nx = CHAR;
            data_nx  = CHAR_FIRST + {1'b0, base};
            valid_nx = 1'b1;
            col_nx   = '0;
         end
         CHAR: if (xfer) begin
            if (col == LAST_COL) begin
               state_nx = CR;
               data_nx  = ASCII_CR;
            end else begin
               col_nx  = col + 8'd1;
               chr_inc = 1'b1;
               data_nx = CHAR_FIRST + {1'b0, chr_succ};
            end
         end
         CR: if (xfer) begin
            state_nx = LF;
            data_nx  = ASCII_LF;
         end
         LF: if (xfer) begin
            base_inc = 1'b1;
            chr_load = 1'b1;
            state_nx = en ? CHAR : IDLE;
            valid_nx = en;
            col_nx   = '0;
            data_nx  = CHAR_FIRST + {1'b0, base_succ};
         end
      endcase
   end

   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         data  <= 8'h00;
         valid <= 1'b0;
         col   <= '0;
      end else begin
         state <= state_nx;
         data  <= data_nx;
         valid <= valid_nx;
         col   <= col_nx;
      end

`ifdef CHARGEN_LED_EN
   logic [2:0] line_cnt;

   always_ff @(posedge clk)
      if (rst) line_cnt <= '0;
      else if (state == LF && xfer) line_cnt <= line_cnt + 3'd1;

   assign led = ~line_cnt;
`endif
endmodule
